// File: rtl/mem_bus_req_pkg.sv
// mem_bus_req_pkg: shared definitions for the MEM-stage bus requester.
// Holds bus widths, FSM state encodings, the stall-request level, the
// watchdog defaults and the latched bus request payload.
package mem_bus_req_pkg;

  localparam int unsigned ADDR_W             = 32;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned SEL_W              = 4;
  localparam int unsigned STALL_W            = 6;
  localparam int unsigned STALL_MEM_BIT      = 4;
  localparam int unsigned WDOG_W             = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  // Stall-request levels seen by the pipeline controller
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // Access captured from the MEM stage and replayed on the bus
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_req_watchdog.sv
// bus_watchdog: cycle counter that flags a bus cycle left unacknowledged for
// TIMEOUT_CYCLES cycles. Only built when MEM_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   enable_i   count this cycle (bus cycle outstanding)
//   clear_i    restart the count (requester changes state)
//   expire_c   combinational: this is the last allowed cycle
`ifdef MEM_BUS_TIMEOUT_EN
module bus_watchdog
  import mem_bus_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_c
);

  logic [WDOG_W-1:0] count_q, count_d;

  // Count outstanding cycles; clear has priority so each state starts at 0
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q is the number of cycles already spent, so this cycle is the Nth
  assign expire_c = enable_i && (count_q == WDOG_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_bus_req.sv
// mem_bus_req: turns a MEM-stage load/store into a single Wishbone-style bus
// cycle, stalling the pipeline until the data is back and surviving flushes
// that arrive while the bus is still busy.
// Optional feature: define MEM_BUS_TIMEOUT_EN to add the bus_watchdog that
// abandons a bus cycle after TIMEOUT_CYCLES unacknowledged cycles.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              pipeline controller stall vector / flush
//   mem_ce_i, mem_we_i        MEM-stage access enable / write
//   mem_addr_i, mem_data_i    access address / store data
//   mem_sel_i                 byte lanes
//   wb_ack_i, wb_dat_i        bus acknowledge / read data
//   wb_cyc_o, wb_stb_o        bus cycle / strobe
//   wb_we_o, wb_adr_o         bus write / address
//   wb_dat_o, wb_sel_o        bus write data / lanes
//   rdata_o                   load result to the MEM stage
//   stallreq_o                combinational stall request
//   bus_err_o                 one-cycle bus timeout pulse
module mem_bus_req
  import mem_bus_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               mem_ce_i,
  input  logic               mem_we_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  input  logic [SEL_W-1:0]   mem_sel_i,
  input  logic               wb_ack_i,
  input  logic [DATA_W-1:0]  wb_dat_i,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [ADDR_W-1:0]  wb_adr_o,
  output logic [DATA_W-1:0]  wb_dat_o,
  output logic [SEL_W-1:0]   wb_sel_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               stallreq_o,
  output logic               bus_err_o
);

  state_e            state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_d;
  logic              on_bus;
  logic              expire_c;
  logic              unused_stall;

  // A bus cycle is outstanding in BUSY and ABORT
  assign on_bus = (state_q == ST_BUSY) || (state_q == ST_ABORT);

  // Only the MEM-stage hold bit matters here
  assign unused_stall = ^(stall & ~(STALL_W'(1) << STALL_MEM_BIT));

`ifdef MEM_BUS_TIMEOUT_EN
  logic bus_err_q;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk      (clk),
    .rst      (rst),
    .enable_i (on_bus),
    .clear_i  (state_d != state_q),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  logic unused_timeout;

  assign expire_c       = 1'b0;
  assign bus_err_o      = 1'b0;
  assign unused_timeout = ^{32'(TIMEOUT_CYCLES), bus_err_d};
`endif

  // Next state, latched request, load data and stall request
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    bus_err_d  = 1'b0;
    stallreq_o = NO_STOP;

    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i && !flush) begin
          stallreq_o = STOP;
          req_d      = '{we: mem_we_i, addr: mem_addr_i, data: mem_data_i, sel: mem_sel_i};
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        stallreq_o = STOP;
        if (wb_ack_i) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            if (!req_q.we) begin
              rdata_d = wb_dat_i;
            end
            state_d = ST_DONE;
          end
        end else if (flush) begin
          // Bus cycle cannot be withdrawn; wait out the ack and drop the data
          state_d = ST_ABORT;
        end else if (expire_c) begin
          rdata_d   = DATA_W'(0);
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // Leave once the instruction advances out of MEM or is flushed
        if (flush || !stall[STALL_MEM_BIT]) begin
          state_d = ST_IDLE;
        end
      end

      ST_ABORT: begin
        // A new MEM access must wait for the orphaned bus cycle
        stallreq_o = mem_ce_i ? STOP : NO_STOP;
        if (wb_ack_i) begin
          state_d = ST_IDLE;
        end else if (expire_c) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_cyc_o = on_bus;
  assign wb_stb_o = on_bus;
  assign wb_we_o  = req_q.we;
  assign wb_adr_o = req_q.addr;
  assign wb_dat_o = req_q.data;
  assign wb_sel_o = req_q.sel;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_bus_req.sv
// tb_mem_bus_req: self-checking bench for mem_bus_req. Stimulus is driven and
// sampled on the falling clock edge; expected values come from transaction
// rules (stall length = latency + 1, loads update the result, stores and
// flushed accesses do not, reset clears it).
module tb_mem_bus_req;

  localparam int unsigned TB_TIMEOUT = 4;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned MAX_LAT = TB_TIMEOUT - 1;
`else
  localparam int unsigned MAX_LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_ce_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_sel_i;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] rdata_o;
  logic        stallreq_o, bus_err_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_bus_req #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .mem_ce_i   (mem_ce_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_sel_i  (mem_sel_i),
    .wb_ack_i   (wb_ack_i),
    .wb_dat_i   (wb_dat_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .rdata_o    (rdata_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = '0; mem_data_i = '0; mem_sel_i = '0; wb_ack_i = 1'b0; wb_dat_i = '0;
    tick(); tick();
    #1;
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, stallreq_o, bus_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc/stb/we/stallreq/err=%b, expected 00000",
               {wb_cyc_o, wb_stb_o, wb_we_o, stallreq_o, bus_err_o});
    end
    checks++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'd0) begin
      errors++;
      $display("FAIL reset_bus: adr=%h dat=%h sel=%h, expected all 0", wb_adr_o, wb_dat_o, wb_sel_o);
    end
    checks++;
    if (rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: rdata=%h, expected 0", rdata_o);
    end
    rst = 1'b0;
    exp_rdata = '0;
    tick();
  endtask

  // One complete access: request, lat BUSY cycles (ack in the last), then
  // hold cycles in DONE with the MEM stage held before it advances.
  task automatic drive_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rd,
                           input logic [3:0] sel, input int lat, input int hold);
    int high = 0;
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_data_i = data; mem_sel_i = sel;
    flush = 1'b0; wb_ack_i = 1'b0; stall = 6'h00;
    #1;
    if (stallreq_o === 1'b1) high++;
    checks++;
    if (wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL %s req_cyc: cyc=%b, expected 0", tag, wb_cyc_o);
    end
    tick();
    for (int k = 1; k <= lat; k++) begin
      stall      = 6'h1F;
      wb_ack_i   = (k == lat);
      wb_dat_i   = (k == lat) ? rd : $urandom();
      // MEM-stage inputs wander; the bus must keep the captured request
      mem_addr_i = $urandom(); mem_data_i = $urandom(); mem_sel_i = 4'($urandom()); mem_we_i = ~we;
      #1;
      if (stallreq_o === 1'b1) high++;
      checks++;
      if ({wb_cyc_o, wb_stb_o} !== 2'b11 || wb_adr_o !== addr || wb_we_o !== we ||
          wb_sel_o !== sel || (we && wb_dat_o !== data)) begin
        errors++;
        $display("FAIL %s busy%0d: cyc/stb=%b%b adr=%h we=%b sel=%h dat=%h, expected 11 adr=%h we=%b sel=%h dat=%h",
                 tag, k, wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o, addr, we, sel, data);
      end
      tick();
    end
    if (!we) exp_rdata = rd;
    wb_ack_i = 1'b0; mem_ce_i = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      stall = (h < hold) ? 6'h3F : 6'h00;
      #1;
      if (stallreq_o === 1'b1) high++;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || stallreq_o !== 1'b0 ||
          rdata_o !== exp_rdata || bus_err_o !== 1'b0) begin
        errors++;
        $display("FAIL %s done%0d: cyc=%b stb=%b stallreq=%b rdata=%h err=%b, expected 0 0 0 %h 0",
                 tag, h, wb_cyc_o, wb_stb_o, stallreq_o, rdata_o, bus_err_o, exp_rdata);
      end
      tick();
    end
    mem_ce_i = 1'b0; stall = 6'h00;
    checks++;
    if (high != lat + 1) begin
      errors++;
      $display("FAIL %s stall_len: stallreq high %0d cycles, expected %0d", tag, high, lat + 1);
    end
  endtask

  task automatic test_load();
    drive_txn("load_lat3", 1'b0, 32'h80000010, 32'h0, 32'hDEADBEEF, 4'hF, 3, 0);
    for (int i = 0; i < 4; i++)
      drive_txn("load_rand", 1'b0, $urandom(), $urandom(), $urandom(), 4'hF,
                int'($urandom_range(MAX_LAT, 1)), 0);
  endtask

  task automatic test_store();
    drive_txn("store_min", 1'b1, 32'h0000_0100, 32'h1234ABCD, 32'hFFFF_0000, 4'b0011, 1, 0);
    for (int i = 0; i < 3; i++)
      drive_txn("store_rand", 1'b1, $urandom(), $urandom(), $urandom(), 4'($urandom()),
                int'($urandom_range(MAX_LAT, 1)), 0);
  endtask

  task automatic test_done_hold();
    drive_txn("done_hold", 1'b0, 32'h0000_2000, 32'h0, 32'hA5A5_5A5A, 4'hF, 1, 5);
  endtask

  task automatic test_flush_abort();
    logic [31:0] addr_a = 32'h0000_3000;
    logic [31:0] addr_b = 32'h0000_4004;
    logic [31:0] rd_b = $urandom();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = addr_a; flush = 1'b0; wb_ack_i = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_flush_cycle: cyc=%b stallreq=%b, expected 1 1", wb_cyc_o, stallreq_o);
    end
    tick();
    flush = 1'b0; mem_ce_i = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || stallreq_o !== 1'b0 || wb_adr_o !== addr_a) begin
      errors++;
      $display("FAIL abort_idle_mem: cyc=%b stallreq=%b adr=%h, expected 1 0 %h", wb_cyc_o, stallreq_o, wb_adr_o, addr_a);
    end
    tick();
    mem_ce_i = 1'b1; mem_addr_i = addr_b;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || stallreq_o !== 1'b1 || wb_adr_o !== addr_a) begin
      errors++;
      $display("FAIL abort_wait: cyc=%b stallreq=%b adr=%h, expected 1 1 %h", wb_cyc_o, stallreq_o, wb_adr_o, addr_a);
    end
    tick();
    wb_ack_i = 1'b1; wb_dat_i = $urandom();
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_ack: cyc=%b stallreq=%b, expected 1 1", wb_cyc_o, stallreq_o);
    end
    tick();
    wb_ack_i = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || stallreq_o !== 1'b1 || rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL abort_restart: cyc=%b stallreq=%b rdata=%h, expected 0 1 %h", wb_cyc_o, stallreq_o, rdata_o, exp_rdata);
    end
    tick();
    wb_ack_i = 1'b1; wb_dat_i = rd_b;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== addr_b) begin
      errors++;
      $display("FAIL abort_new_access: cyc=%b adr=%h, expected 1 %h", wb_cyc_o, wb_adr_o, addr_b);
    end
    tick();
    exp_rdata = rd_b;
    wb_ack_i = 1'b0; stall = 6'h00;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL abort_new_done: stallreq=%b rdata=%h, expected 0 %h", stallreq_o, rdata_o, exp_rdata);
    end
    tick();
    mem_ce_i = 1'b0;
  endtask

  task automatic test_flush_ack();
    logic [31:0] rd = $urandom();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_5000; flush = 1'b0; wb_ack_i = 1'b0;
    tick();
    flush = 1'b1; wb_ack_i = 1'b1; wb_dat_i = $urandom();
    tick();
    flush = 1'b0; wb_ack_i = 1'b0; mem_ce_i = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || stallreq_o !== 1'b0 || rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL flush_ack_discard: cyc=%b stallreq=%b rdata=%h, expected 0 0 %h", wb_cyc_o, stallreq_o, rdata_o, exp_rdata);
    end
    tick();
    mem_ce_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_ack_idle: stallreq=%b, expected 1", stallreq_o);
    end
    tick();
    wb_ack_i = 1'b1; wb_dat_i = rd;
    tick();
    exp_rdata = rd;
    wb_ack_i = 1'b0; stall = 6'h00;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL flush_ack_next: stallreq=%b rdata=%h, expected 0 %h", stallreq_o, rdata_o, exp_rdata);
    end
    tick();
    mem_ce_i = 1'b0;
  endtask

  task automatic test_flush_done();
    logic [31:0] rd = $urandom();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_6000; flush = 1'b0; wb_ack_i = 1'b0;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = rd;
    tick();
    exp_rdata = rd;
    wb_ack_i = 1'b0; stall = 6'h3F; flush = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0 || rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL flush_done: stallreq=%b rdata=%h, expected 0 %h", stallreq_o, rdata_o, exp_rdata);
    end
    tick();
    flush = 1'b0; mem_addr_i = 32'h0000_6004;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_idle: stallreq=%b, expected 1", stallreq_o);
    end
    tick();
    rd = $urandom();
    wb_ack_i = 1'b1; wb_dat_i = rd;
    tick();
    exp_rdata = rd;
    wb_ack_i = 1'b0; stall = 6'h00;
    tick();
    mem_ce_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd = $urandom();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_7000; flush = 1'b0; wb_ack_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ce_i = 1'b0;
    exp_rdata = '0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || stallreq_o !== 1'b0 || rdata_o !== 32'd0 || wb_adr_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: cyc=%b stb=%b stallreq=%b rdata=%h adr=%h, expected 0 0 0 0 0",
               wb_cyc_o, wb_stb_o, stallreq_o, rdata_o, wb_adr_o);
    end
    tick();
    mem_ce_i = 1'b1;
    tick();
    wb_ack_i = 1'b1; wb_dat_i = rd;
    tick();
    exp_rdata = rd;
    wb_ack_i = 1'b0; stall = 6'h00;
    #1;
    checks++;
    if (rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL reset_mid_recover: rdata=%h, expected %h", rdata_o, exp_rdata);
    end
    tick();
    mem_ce_i = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      drive_txn("random", 1'($urandom()), $urandom(), $urandom(), $urandom(), 4'($urandom()),
                int'($urandom_range(MAX_LAT, 1)), int'($urandom_range(3, 0)));
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_8000; flush = 1'b0; wb_ack_i = 1'b0;
    tick();
    for (int k = 1; k <= int'(TB_TIMEOUT); k++) begin
      #1;
      checks++;
      if (wb_cyc_o !== 1'b1 || bus_err_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_busy%0d: cyc=%b err=%b, expected 1 0", k, wb_cyc_o, bus_err_o);
      end
      tick();
    end
    exp_rdata = '0;
    stall = 6'h00;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || bus_err_o !== 1'b1 || rdata_o !== 32'd0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_expire: cyc=%b err=%b rdata=%h stallreq=%b, expected 0 1 0 0",
               wb_cyc_o, bus_err_o, rdata_o, stallreq_o);
    end
    tick();
    mem_ce_i = 1'b0;
    #1;
    checks++;
    if (bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b, expected 0", bus_err_o);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    logic [31:0] rd = $urandom();
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_9000; flush = 1'b0; wb_ack_i = 1'b0;
    tick();
    for (int k = 0; k < 300; k++) begin
      #1;
      if (wb_cyc_o !== 1'b1 || stallreq_o !== 1'b1 || bus_err_o !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_timeout_wait: %0d cycles lost the bus cycle, expected 0", bad);
    end
    wb_ack_i = 1'b1; wb_dat_i = rd;
    tick();
    exp_rdata = rd;
    wb_ack_i = 1'b0; stall = 6'h00;
    #1;
    checks++;
    if (rdata_o !== exp_rdata || bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_done: rdata=%h err=%b, expected %h 0", rdata_o, bus_err_o, exp_rdata);
    end
    tick();
    mem_ce_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_done_hold();
    test_flush_abort();
    test_flush_ack();
    test_flush_done();
    test_reset_mid();
    test_random();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
